// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 backing-store subordinate, single-beat writes and INCR read bursts.
module axi_mem_responder #(
  parameter int AxiIdWidth = 4,
  parameter int AxiAddrWidth = 64,
  parameter int AxiDataWidth = 64,
  parameter int MemWords = 1024,
  parameter logic [AxiAddrWidth-1:0] BaseAddr = AxiAddrWidth'(64'h8000_0000)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  input  logic [AxiIdWidth-1:0]     aw_id_i,
  input  logic [AxiAddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]                aw_len_i,
  input  logic [5:0]                aw_atop_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [AxiDataWidth-1:0]   w_data_i,
  input  logic [AxiDataWidth/8-1:0] w_strb_i,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  output logic [AxiIdWidth-1:0]     b_id_o,
  output logic [1:0]                b_resp_o,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [AxiIdWidth-1:0]     ar_id_i,
  input  logic [AxiAddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]                ar_len_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [AxiIdWidth-1:0]     r_id_o,
  output logic [AxiDataWidth-1:0]   r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o
);
  localparam int NB = AxiDataWidth / 8;
  localparam int OFF = $clog2(NB);
  localparam int MW = $clog2(MemWords);
  localparam logic [AxiAddrWidth-1:0] MEM_WORDS = AxiAddrWidth'(MemWords);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_BURST} r_state_e;
  logic [AxiDataWidth-1:0] mem [MemWords];
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
  logic [AxiIdWidth-1:0] b_id_q, b_id_d, aw_id_q, aw_id_d;
  logic [1:0] b_resp_q, b_resp_d;
  logic [AxiAddrWidth-1:0] aw_addr_q, aw_addr_d;
  logic [7:0] aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [5:0] aw_atop_q, aw_atop_d;
  logic ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d;
  logic r_base_ok_q, r_base_ok_d;
  logic [AxiIdWidth-1:0] r_id_q, r_id_d;
  logic [AxiDataWidth-1:0] r_data_q, r_data_d;
  logic [1:0] r_resp_q, r_resp_d;
  logic [AxiAddrWidth-1:0] r_idx_q, r_idx_d;
  logic [7:0] r_len_q, r_len_d, r_k_q, r_k_d;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_in, we, rd_load, rd_base_ok, rd_ok;
  logic [AxiAddrWidth-1:0] aw_idx, rd_idx;
  logic [AxiAddrWidth:0] rd_sum;
  logic [7:0] rd_k, rd_len;
  logic [AxiDataWidth-1:0] rd_word;
  assign aw_hs = aw_valid_i & aw_ready_q;
  assign w_hs = w_valid_i & w_ready_q;
  assign b_hs = b_valid_q & b_ready_i;
  assign ar_hs = ar_valid_i & ar_ready_q;
  assign r_hs = r_valid_q & r_ready_i;
  assign aw_idx = (aw_addr_q - BaseAddr) >> OFF;
  assign aw_in = aw_addr_q >= BaseAddr && aw_idx < MEM_WORDS;
  assign we = rst_ni && w_hs && aw_len_q == 8'd0 && aw_atop_q == 6'd0 && aw_in;
  // Next read beat: either beat 0 of a newly accepted AR or the successor of the current beat
  assign rd_load = ar_hs || (r_hs && !r_last_q);
  assign rd_base_ok = ar_hs ? ar_addr_i >= BaseAddr : r_base_ok_q;
  assign rd_idx = ar_hs ? (ar_addr_i - BaseAddr) >> OFF : r_idx_q;
  assign rd_k = ar_hs ? 8'd0 : r_k_q + 8'd1;
  assign rd_len = ar_hs ? ar_len_i : r_len_q;
  assign rd_sum = {1'b0, rd_idx} + (AxiAddrWidth+1)'(rd_k);
  assign rd_ok = rd_base_ok && !rd_sum[AxiAddrWidth] && rd_sum[AxiAddrWidth-1:0] < MEM_WORDS;
  assign rd_word = mem[rd_sum[MW-1:0]];
  always_comb begin
    w_state_d = w_state_q;
    aw_ready_d = aw_ready_q;
    w_ready_d = w_ready_q;
    b_valid_d = b_valid_q;
    b_id_d = b_id_q;
    b_resp_d = b_resp_q;
    aw_id_d = aw_id_q;
    aw_addr_d = aw_addr_q;
    aw_len_d = aw_len_q;
    aw_atop_d = aw_atop_q;
    w_cnt_d = w_cnt_q;
    case (w_state_q)
      W_IDLE: begin
        aw_ready_d = !aw_hs;
        if (aw_hs) begin
          w_state_d = W_DATA;
          w_ready_d = 1'b1;
          aw_id_d = aw_id_i;
          aw_addr_d = aw_addr_i;
          aw_len_d = aw_len_i;
          aw_atop_d = aw_atop_i;
          w_cnt_d = 8'd0;
        end
      end
      W_DATA: if (w_hs) begin
        w_cnt_d = w_cnt_q + 8'd1;
        if (w_cnt_q == aw_len_q) begin
          w_state_d = W_RESP;
          w_ready_d = 1'b0;
          b_valid_d = 1'b1;
          b_id_d = aw_id_q;
          b_resp_d = (aw_atop_q != 6'd0 || aw_len_q != 8'd0) ? SLVERR : aw_in ? OKAY : DECERR;
        end
      end
      W_RESP: if (b_hs) begin
        w_state_d = W_IDLE;
        b_valid_d = 1'b0;
        aw_ready_d = 1'b1;
      end
      default: w_state_d = W_IDLE;
    endcase
  end
  always_comb begin
    r_state_d = r_state_q;
    ar_ready_d = ar_ready_q;
    r_valid_d = r_valid_q;
    r_last_d = r_last_q;
    r_id_d = r_id_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    r_idx_d = r_idx_q;
    r_base_ok_d = r_base_ok_q;
    r_len_d = r_len_q;
    r_k_d = r_k_q;
    case (r_state_q)
      R_IDLE: begin
        ar_ready_d = !ar_hs;
        if (ar_hs) begin
          r_state_d = R_BURST;
          r_valid_d = 1'b1;
          r_id_d = ar_id_i;
          r_idx_d = rd_idx;
          r_base_ok_d = rd_base_ok;
          r_len_d = ar_len_i;
          r_k_d = 8'd0;
        end
      end
      R_BURST: if (r_hs) begin
        r_k_d = rd_k;
        if (r_last_q) begin
          r_state_d = R_IDLE;
          r_valid_d = 1'b0;
          r_last_d = 1'b0;
          ar_ready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (rd_load) begin
      r_data_d = rd_ok ? rd_word : '0;
      r_resp_d = rd_ok ? OKAY : DECERR;
      r_last_d = rd_k == rd_len;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q <= 1'b0;
      b_valid_q <= 1'b0;
      b_id_q <= '0;
      b_resp_q <= '0;
      aw_id_q <= '0;
      aw_addr_q <= '0;
      aw_len_q <= '0;
      aw_atop_q <= '0;
      w_cnt_q <= '0;
      r_state_q <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q <= 1'b0;
      r_last_q <= 1'b0;
      r_id_q <= '0;
      r_data_q <= '0;
      r_resp_q <= '0;
      r_idx_q <= '0;
      r_base_ok_q <= 1'b0;
      r_len_q <= '0;
      r_k_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q <= w_ready_d;
      b_valid_q <= b_valid_d;
      b_id_q <= b_id_d;
      b_resp_q <= b_resp_d;
      aw_id_q <= aw_id_d;
      aw_addr_q <= aw_addr_d;
      aw_len_q <= aw_len_d;
      aw_atop_q <= aw_atop_d;
      w_cnt_q <= w_cnt_d;
      r_state_q <= r_state_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q <= r_valid_d;
      r_last_q <= r_last_d;
      r_id_q <= r_id_d;
      r_data_q <= r_data_d;
      r_resp_q <= r_resp_d;
      r_idx_q <= r_idx_d;
      r_base_ok_q <= r_base_ok_d;
      r_len_q <= r_len_d;
      r_k_q <= r_k_d;
    end
  end
  always_ff @(posedge clk_i)
    if (we)
      for (int i = 0; i < NB; i++)
        if (w_strb_i[i]) mem[aw_idx[MW-1:0]][8*i +: 8] <= w_data_i[8*i +: 8];
  assign aw_ready_o = aw_ready_q;
  assign w_ready_o = w_ready_q;
  assign b_valid_o = b_valid_q;
  assign b_id_o = b_id_q;
  assign b_resp_o = b_resp_q;
  assign ar_ready_o = ar_ready_q;
  assign r_valid_o = r_valid_q;
  assign r_last_o = r_last_q;
  assign r_id_o = r_id_q;
  assign r_data_o = r_data_q;
  assign r_resp_o = r_resp_q;
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed AXI transactions checked against an address-level memory model.
module tb_axi_mem_responder;
  localparam logic [63:0] BASE = 64'h8000_0000;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic aw_valid = 0, w_valid = 0, b_ready = 0, ar_valid = 0, r_ready = 0;
  logic [3:0] aw_id = 0, ar_id = 0;
  logic [63:0] aw_addr = 0, ar_addr = 0, w_data = 0;
  logic [7:0] aw_len = 0, ar_len = 0, w_strb = 0;
  logic [5:0] aw_atop = 0;
  logic aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o;
  logic [3:0] b_id_o, r_id_o;
  logic [1:0] b_resp_o, r_resp_o;
  logic [63:0] r_data_o;
  int compared = 0, failed = 0;
  typedef struct {logic [3:0] id; logic [1:0] resp;} b_t;
  typedef struct {logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last;} r_t;
  b_t bq[$];
  r_t rq[$];
  logic [63:0] mdl [longint];
  logic [3:0] last_b_id, last_r_id;
  logic [1:0] last_b_resp, last_r_resp;
  logic [63:0] last_r_data;
  logic last_r_last;

  axi_mem_responder dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
    .aw_len_i(aw_len), .aw_atop_i(aw_atop),
    .w_valid_i(w_valid), .w_ready_o(w_ready_o), .w_data_i(w_data), .w_strb_i(w_strb),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
    .ar_len_i(ar_len),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o)
  );

  always #5 clk = ~clk;

  // Address-level rule: DECERR below the base or past the last word (with 65-bit sum)
  function automatic logic [1:0] rng(input logic [63:0] a, input int k);
    logic [64:0] s;
    if (a < BASE) return 2'b11;
    s = {1'b0, (a - BASE) >> 3} + 65'(k);
    return (s >= 65'd1024) ? 2'b11 : 2'b00;
  endfunction

  function automatic longint widx(input logic [63:0] a, input int k);
    return longint'((a - BASE) >> 3) + longint'(k);
  endfunction

  function automatic logic sig(input int w);
    return w == 0 ? aw_ready_o : w == 1 ? w_ready_o : w == 2 ? b_valid_o : w == 3 ? ar_ready_o : r_valid_o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic wait_rdy(input int w, input string nm);
    int n = 0;
    @(negedge clk);
    while (!sig(w) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!sig(w)) begin
      compared++;
      failed++;
      $display("FAIL %s_timeout: got 0 required 1", nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mon();
    if (!rst_ni) return;
    if (b_valid_o) begin
      compared++;
      if (bq.size() == 0) begin
        failed++;
        $display("FAIL b_unexpected: got id=%h resp=%h required no response", b_id_o, b_resp_o);
      end else begin
        if (b_id_o !== bq[0].id || b_resp_o !== bq[0].resp) begin
          failed++;
          $display("FAIL b_resp: got id=%h resp=%h required id=%h resp=%h", b_id_o, b_resp_o, bq[0].id, bq[0].resp);
        end
        if (b_ready) begin
          last_b_id = b_id_o;
          last_b_resp = b_resp_o;
          void'(bq.pop_front());
        end
      end
    end
    if (r_valid_o) begin
      compared++;
      if (rq.size() == 0) begin
        failed++;
        $display("FAIL r_unexpected: got id=%h data=%h required no beat", r_id_o, r_data_o);
      end else begin
        if (r_id_o !== rq[0].id || r_data_o !== rq[0].data || r_resp_o !== rq[0].resp || r_last_o !== rq[0].last) begin
          failed++;
          $display("FAIL r_beat: got id=%h data=%h resp=%h last=%b required id=%h data=%h resp=%h last=%b",
                   r_id_o, r_data_o, r_resp_o, r_last_o, rq[0].id, rq[0].data, rq[0].resp, rq[0].last);
        end
        if (r_ready) begin
          last_r_id = r_id_o;
          last_r_data = r_data_o;
          last_r_resp = r_resp_o;
          last_r_last = r_last_o;
          void'(rq.pop_front());
        end
      end
    end
  endtask

  task automatic wr(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                    input logic [5:0] atop, input logic [63:0] d, input logic [7:0] s);
    logic [1:0] resp = (atop != 0 || len != 0) ? 2'b10 : rng(a, 0);
    longint ix = widx(a, 0);
    if (resp == 2'b00) begin
      if (!mdl.exists(ix)) mdl[ix] = 64'd0;
      for (int i = 0; i < 8; i++) if (s[i]) mdl[ix][8*i +: 8] = d[8*i +: 8];
    end
    bq.push_back('{id, resp});
    aw_valid = 1; aw_id = id; aw_addr = a; aw_len = len; aw_atop = atop;
    wait_rdy(0, "aw");
    aw_valid = 0; w_valid = 1; w_data = d; w_strb = s;
    for (int b = 0; b <= int'(len); b++) wait_rdy(1, "w");
    w_valid = 0; b_ready = 1;
    wait_rdy(2, "b");
    b_ready = 0;
  endtask

  task automatic push_r(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len);
    for (int k = 0; k <= int'(len); k++) begin
      logic [1:0] resp = rng(a, k);
      longint ix = widx(a, k);
      rq.push_back('{id, (resp == 2'b00 && mdl.exists(ix)) ? mdl[ix] : 64'd0, resp, k == int'(len)});
    end
  endtask

  task automatic rd(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len, input int stall);
    push_r(id, a, len);
    ar_valid = 1; ar_id = id; ar_addr = a; ar_len = len;
    wait_rdy(3, "ar");
    ar_valid = 0;
    repeat (stall) @(posedge clk);
    #1 r_ready = 1;
    for (int k = 0; k <= int'(len); k++) wait_rdy(4, "r");
    r_ready = 0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        mon();
      end
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_ready", 64'(aw_ready_o), 0);
    chk("rst_ar_ready", 64'(ar_ready_o), 0);
    chk("rst_valids", {b_valid_o, r_valid_o, r_last_o, w_ready_o}, 0);
    chk("rst_payload", r_data_o | 64'(b_id_o) | 64'(r_id_o) | 64'(b_resp_o) | 64'(r_resp_o), 0);
    @(posedge clk); #1 rst_ni = 1;
    @(posedge clk); @(negedge clk);
    chk("idle_ready", {aw_ready_o, ar_ready_o, w_ready_o}, 3'b110);
    @(posedge clk); #1;
    wr(4'd3, 64'h8000_0010, 8'd0, 6'd0, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    chk("b_basic_id", 64'(last_b_id), 3);
    chk("b_basic_resp", 64'(last_b_resp), 0);
    rd(4'd5, 64'h8000_0010, 8'd0, 0);
    chk("r_basic_data", last_r_data, 64'hDEADBEEF_CAFEF00D);
    chk("r_basic_last", {last_r_id, last_r_resp, last_r_last}, {4'd5, 2'b00, 1'b1});
    rd(4'd6, 64'h8000_0017, 8'd0, 0);
    chk("r_lowbits", last_r_data, 64'hDEADBEEF_CAFEF00D);
    wr(4'd1, 64'h8000_0020, 8'd0, 6'd0, 64'h11223344_55667788, 8'hFF);
    wr(4'd2, 64'h8000_0020, 8'd0, 6'd0, 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
    rd(4'd7, 64'h8000_0020, 8'd0, 0);
    chk("r_partial", last_r_data, 64'h11223344_BBBBBBBB);
    wr(4'd0, 64'h8000_0000, 8'd0, 6'd0, 64'h01234567_89ABCDEF, 8'hFF);
    wr(4'd0, 64'h8000_0008, 8'd0, 6'd0, 64'hFEDCBA98_76543210, 8'hFF);
    rd(4'd9, 64'h8000_0000, 8'd1, 5);
    chk("r_burst_last", last_r_data, 64'hFEDCBA98_76543210);
    chk("r_burst_id", {last_r_id, last_r_last}, {4'd9, 1'b1});
    wr(4'd4, 64'h8000_0010, 8'd3, 6'd0, 64'd0, 8'hFF);
    chk("b_len_slverr", 64'(last_b_resp), 2);
    wr(4'd4, 64'h8000_0010, 8'd0, 6'h20, 64'd0, 8'hFF);
    chk("b_atop_slverr", 64'(last_b_resp), 2);
    rd(4'd1, 64'h8000_0010, 8'd0, 0);
    chk("r_unchanged", last_r_data, 64'hDEADBEEF_CAFEF00D);
    wr(4'd8, 64'h7FFF_FFF8, 8'd0, 6'd0, 64'h1, 8'hFF);
    chk("b_low_decerr", 64'(last_b_resp), 3);
    wr(4'd8, 64'h8000_2000, 8'd0, 6'd0, 64'h1, 8'hFF);
    chk("b_high_decerr", 64'(last_b_resp), 3);
    rd(4'd2, 64'h7FFF_FFF8, 8'd0, 0);
    chk("r_low_decerr", {last_r_data, last_r_resp}, {64'd0, 2'b11});
    wr(4'd3, 64'h8000_1FF8, 8'd0, 6'd0, 64'h5A5A5A5A_A5A5A5A5, 8'hFF);
    rd(4'd3, 64'h8000_1FF8, 8'd1, 0);
    chk("r_edge_beat1", {last_r_data, last_r_resp, last_r_last}, {64'd0, 2'b11, 1'b1});
    push_r(4'd6, 64'h8000_0000, 8'd1);
    ar_valid = 1; ar_id = 4'd6; ar_addr = 64'h8000_0000; ar_len = 8'd1;
    wait_rdy(3, "ar_abort");
    ar_valid = 0;
    @(negedge clk);
    chk("abort_pre_valid", 64'(r_valid_o), 1);
    @(posedge clk); #1 rst_ni = 0;
    rq.delete();
    @(posedge clk); @(negedge clk);
    chk("abort_valid", {r_valid_o, ar_ready_o}, 0);
    @(posedge clk); #1 rst_ni = 1;
    @(posedge clk); @(negedge clk);
    chk("abort_recover", {ar_ready_o, r_valid_o}, 2'b10);
    @(posedge clk); #1;
    rd(4'd7, 64'h8000_0008, 8'd0, 0);
    chk("r_after_reset", last_r_data, 64'hFEDCBA98_76543210);
    repeat (3) @(posedge clk);
    chk("queues_drained", 64'(bq.size() + rq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
